cycle_counter_bank: RTL and testbench
=====================================

// Module: cycle_counter_bank
// PURPOSE
//   Bank of CHANNELS independent cycle counters for CPU performance measurement.
//   Each channel counts clock cycles while its halt input is low, e.g. total,
//   stall and memory-wait cycles. Adds per-channel clear, global freeze,
//   wrap/saturate mode, sticky overflow flags and a snapshot readout port.
//   The bank sits beside the CPU datapath and is read by the debug/display logic.
// PARAMETERS
//   WIDTH     16  counter width in bits, >= 2
//   CHANNELS  4   number of counters, 1..16
//   SEL_W     2   width of sel; 2**SEL_W >= CHANNELS
//   SATURATE  0   0 = wrap at all-ones, 1 = hold at all-ones
// PORTS
//   clk       in   1                 clock; all state updates on posedge
//   RST       in   1                 synchronous reset, active-high
//   halt      in   CHANNELS          bit i = 1 pauses channel i; 0 counts
//   clr       in   CHANNELS          bit i = 1 zeroes counter i and ovf[i]
//   freeze    in   1                 1 = pause all channels
//   snap      in   1                 1 = copy all live counters to shadow regs
//   sel       in   SEL_W             shadow channel select for rd_data
//   rd_data   out  WIDTH             registered shadow[sel]
//   cnt_flat  out  WIDTH*CHANNELS    live counters; channel i at [i*WIDTH +: WIDTH]
//   ovf       out  CHANNELS          sticky overflow flag per channel
//   snap_vld  out  1                 1 once any snapshot has been taken
// BEHAVIOUR
//   Reset (RST=1 at posedge): all counters, shadows, rd_data, ovf and snap_vld
//     are 0. RST overrides every other input.
//   Per-channel priority at each posedge when RST=0:
//     clr[i] > (freeze | halt[i]) > increment.
//     clr[i]=1: cnt[i] <= 0 and ovf[i] <= 0.
//     freeze=1 or halt[i]=1: cnt[i] holds.
//     Otherwise cnt[i] increments by 1.
//   Count latency: an edge at which channel i is enabled updates cnt_flat
//     immediately after that edge.
//   Overflow, enabled increment with cnt[i] = all-ones:
//     SATURATE=0: cnt[i] <= 0 and ovf[i] <= 1.
//     SATURATE=1: cnt[i] holds all-ones and ovf[i] <= 1.
//     ovf[i] stays set until clr[i] or RST.
//   Snapshot: snap=1 at an edge loads shadow[i] <= cnt[i] (value before that
//     edge's update) for all i. A simultaneous clr or increment does not affect
//     the captured value. snap_vld <= 1 and stays 1 until RST.
//   Readout: at every posedge, rd_data <= shadow[sel], or 0 if sel >= CHANNELS.
//     Latency is 1 cycle from sel; 2 cycles from snap to the new value on rd_data.
//   Freeze does not block snap, clr or the readout.
//   Channels are fully independent; no cross-channel carry.
//   No state machine: a per-channel register update plus the shadow bank.
// TESTING
//   1. RST=1 for 2 cycles, then halt=0, freeze=0 for 10 cycles
//      -> every channel reads 10, ovf=0, snap_vld=0, rd_data=0.
//   2. halt=4'b0010 for 5 cycles from reset
//      -> ch0=5, ch1=0, ch2=5, ch3=5; release halt[1] for 3 cycles -> ch1=3.
//   3. WIDTH=4, SATURATE=0, 17 enabled cycles -> cnt=1, ovf=1.
//      With SATURATE=1 -> cnt=15, ovf=1. Then pulse clr[0] -> cnt0=0, ovf[0]=0.
//   4. Counters at 7, snap and clr[2] in the same cycle, then sel=2
//      -> rd_data=7 two edges after snap, cnt2=0, snap_vld=1.
//   5. freeze=1 for 4 cycles mid-count -> all counters hold.
//      snap during freeze captures the held values; counting resumes on release.
//   6. RST mid-count with snap=1 and clr=1 asserted -> all outputs 0, snap_vld=0.
//      sel=3 with CHANNELS=3 -> rd_data=0.

Source files
------------

// File: rtl/cycle_counter_bank.sv
// rtl/cycle_counter_bank.sv - bank of independent cycle counters with sticky overflow and snapshot readout
// Each channel counts enabled cycles; a snapshot copies all live counts into a shadow bank for readout.
module cycle_counter_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       halt,
  input  logic [CHANNELS-1:0]       clr,
  input  logic                      freeze,
  input  logic                      snap,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          rd_data,
  output logic [WIDTH*CHANNELS-1:0] cnt_flat,
  output logic [CHANNELS-1:0]       ovf,
  output logic                      snap_vld
);

  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;
  logic [WIDTH-1:0]    rd_q;
  logic [WIDTH-1:0]    rd_d;
  logic                snap_vld_q;
  logic                snap_vld_d;

  always_comb begin
    ovf_d      = ovf_q;
    snap_vld_d = snap_vld_q | snap;
    rd_d       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i];
      // Shadow captures the pre-update count, so same-edge clr/increment is invisible here.
      shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
      if (sel == SEL_W'(i)) begin
        rd_d = shadow_q[i];
      end
      if (clr[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (!(freeze || halt[i])) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? '1 : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ovf_q      <= '0;
      rd_q       <= '0;
      snap_vld_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      ovf_q      <= ovf_d;
      rd_q       <= rd_d;
      snap_vld_q <= snap_vld_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_flat[i*WIDTH +: WIDTH] = cnt_q[i];
    end
  end

  assign rd_data  = rd_q;
  assign ovf      = ovf_q;
  assign snap_vld = snap_vld_q;

endmodule

// File: tb/tb_cycle_counter_bank.sv
// tb/tb_cycle_counter_bank.sv - self-checking bench for cycle_counter_bank against a behavioural model
// Three instances (16-bit/4ch wrap, 4-bit/3ch wrap, 4-bit/3ch saturate) share one stimulus stream.
module tb_cycle_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] halt;
  logic [3:0] clr;
  logic       freeze;
  logic       snap;
  logic [1:0] sel;

  logic [15:0] rd_a;
  logic [63:0] cnt_a;
  logic [3:0]  ovf_a;
  logic        sv_a;
  logic [3:0]  rd_b, rd_c;
  logic [11:0] cnt_b, cnt_c;
  logic [2:0]  ovf_b, ovf_c;
  logic        sv_b, sv_c;

  always #5 clk = ~clk;

  cycle_counter_bank #(.WIDTH(16), .CHANNELS(4), .SEL_W(2), .SATURATE(0)) u_a (
    .clk(clk), .RST(rst), .halt(halt), .clr(clr), .freeze(freeze), .snap(snap), .sel(sel),
    .rd_data(rd_a), .cnt_flat(cnt_a), .ovf(ovf_a), .snap_vld(sv_a));
  cycle_counter_bank #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .SATURATE(0)) u_b (
    .clk(clk), .RST(rst), .halt(halt[2:0]), .clr(clr[2:0]), .freeze(freeze), .snap(snap), .sel(sel),
    .rd_data(rd_b), .cnt_flat(cnt_b), .ovf(ovf_b), .snap_vld(sv_b));
  cycle_counter_bank #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .SATURATE(1)) u_c (
    .clk(clk), .RST(rst), .halt(halt[2:0]), .clr(clr[2:0]), .freeze(freeze), .snap(snap), .sel(sel),
    .rd_data(rd_c), .cnt_flat(cnt_c), .ovf(ovf_c), .snap_vld(sv_c));

  int W[3]   = '{16, 4, 4};
  int NCH[3] = '{4, 3, 3};
  int SAT[3] = '{0, 0, 1};

  int m_cnt[3][4];
  int m_sh[3][4];
  int m_ovf[3][4];
  int m_rd[3];
  int m_sv[3];

  int  checks = 0;
  int  errors = 0;
  bit  started = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: plain per-channel arithmetic applied with the inputs present at each edge.
  task automatic model_step();
    int modv;
    int nxt;
    for (int d = 0; d < 3; d++) begin
      modv = 1 << W[d];
      if (rst) begin
        m_rd[d] = 0;
        m_sv[d] = 0;
        for (int i = 0; i < 4; i++) begin
          m_cnt[d][i] = 0; m_sh[d][i] = 0; m_ovf[d][i] = 0;
        end
      end else begin
        m_rd[d] = (int'(sel) < NCH[d]) ? m_sh[d][sel] : 0;
        if (snap) begin
          m_sv[d] = 1;
          for (int i = 0; i < NCH[d]; i++) m_sh[d][i] = m_cnt[d][i];
        end
        for (int i = 0; i < NCH[d]; i++) begin
          if (clr[i]) begin
            m_cnt[d][i] = 0;
            m_ovf[d][i] = 0;
          end else if (!(freeze || halt[i])) begin
            nxt = m_cnt[d][i] + 1;
            if (nxt >= modv) begin
              m_ovf[d][i] = 1;
              nxt = (SAT[d] != 0) ? modv - 1 : nxt - modv;
            end
            m_cnt[d][i] = nxt;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic [63:0] dut_cnt(int d, int i);
    case (d)
      0:       return 64'(cnt_a[i*16 +: 16]);
      1:       return 64'(cnt_b[i*4 +: 4]);
      default: return 64'(cnt_c[i*4 +: 4]);
    endcase
  endfunction

  function automatic logic [63:0] dut_ovf(int d, int i);
    case (d)
      0:       return 64'(ovf_a[i]);
      1:       return 64'(ovf_b[i]);
      default: return 64'(ovf_c[i]);
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < NCH[d]; i++) begin
          chk($sformatf("d%0d_cnt%0d", d, i), dut_cnt(d, i), 64'(m_cnt[d][i]));
          chk($sformatf("d%0d_ovf%0d", d, i), dut_ovf(d, i), 64'(m_ovf[d][i]));
        end
      end
      chk("a_rd", 64'(rd_a), 64'(m_rd[0]));
      chk("b_rd", 64'(rd_b), 64'(m_rd[1]));
      chk("c_rd", 64'(rd_c), 64'(m_rd[2]));
      chk("a_sv", 64'(sv_a), 64'(m_sv[0]));
      chk("b_sv", 64'(sv_b), 64'(m_sv[1]));
      chk("c_sv", 64'(sv_c), 64'(m_sv[2]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; halt = 0; clr = 0; freeze = 0; snap = 0; sel = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(2);
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(2);
    started = 1;
    chk("rst_cnt_a", cnt_a, 64'd0);
    chk("rst_ovf_a", 64'(ovf_a), 64'd0);
    chk("rst_rd_a", 64'(rd_a), 64'd0);

    // 1: ten free-running cycles
    rst = 0;
    tick(10);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_ch%0d", i), dut_cnt(0, i), 64'd10);
    chk("t1_model", 64'(m_cnt[0][0]), 64'd10);
    chk("t1_ovf", 64'(ovf_a), 64'd0);
    chk("t1_sv", 64'(sv_a), 64'd0);
    chk("t1_rd", 64'(rd_a), 64'd0);

    // 2: channel 1 halted
    do_reset();
    halt = 4'b0010;
    tick(5);
    chk("t2_ch0", dut_cnt(0, 0), 64'd5);
    chk("t2_ch1", dut_cnt(0, 1), 64'd0);
    chk("t2_ch2", dut_cnt(0, 2), 64'd5);
    chk("t2_ch3", dut_cnt(0, 3), 64'd5);
    halt = 4'b0000;
    tick(3);
    chk("t2_ch1_rel", dut_cnt(0, 1), 64'd3);

    // 3: 4-bit overflow, wrap vs saturate, then clear
    do_reset();
    tick(17);
    chk("t3_wrap_cnt", dut_cnt(1, 0), 64'd1);
    chk("t3_wrap_ovf", dut_ovf(1, 0), 64'd1);
    chk("t3_sat_cnt", dut_cnt(2, 0), 64'd15);
    chk("t3_sat_ovf", dut_ovf(2, 0), 64'd1);
    chk("t3_model_sat", 64'(m_cnt[2][1]), 64'd15);
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    chk("t3_clr_cnt", dut_cnt(2, 0), 64'd0);
    chk("t3_clr_ovf", dut_ovf(2, 0), 64'd0);
    chk("t3_keep_ovf", dut_ovf(2, 1), 64'd1);
    chk("t3_wrap_ch1", dut_cnt(1, 1), 64'd2);

    // 4: snap and clr[2] in the same cycle
    do_reset();
    tick(7);
    snap = 1; clr = 4'b0100; sel = 2;
    tick(1);
    snap = 0; clr = 0;
    chk("t4_cnt2", dut_cnt(0, 2), 64'd0);
    chk("t4_sv", 64'(sv_a), 64'd1);
    chk("t4_rd_early", 64'(rd_a), 64'd0);
    tick(1);
    chk("t4_rd", 64'(rd_a), 64'd7);

    // 5: freeze with a snapshot inside it
    do_reset();
    tick(5);
    freeze = 1;
    tick(1);
    snap = 1;
    tick(1);
    snap = 0; sel = 1;
    tick(2);
    chk("t5_hold", dut_cnt(0, 3), 64'd5);
    chk("t5_rd", 64'(rd_a), 64'd5);
    freeze = 0;
    tick(3);
    chk("t5_resume", dut_cnt(0, 0), 64'd8);

    // 6: out-of-range select, then reset beats snap/clr
    do_reset();
    tick(6);
    snap = 1;
    tick(1);
    snap = 0; sel = 3;
    tick(2);
    chk("t6_rd_oob", 64'(rd_b), 64'd0);
    chk("t6_rd_a3", 64'(rd_a), 64'd6);
    rst = 1; snap = 1; clr = 4'b1111;
    tick(1);
    chk("t6_cnt", cnt_a, 64'd0);
    chk("t6_sv", 64'(sv_a), 64'd0);
    chk("t6_ovf", 64'(ovf_b), 64'd0);
    idle();

    // Random phase, compared by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      halt   = 4'($urandom) & 4'($urandom);
      clr    = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      freeze = ($urandom_range(0, 7) == 0);
      snap   = ($urandom_range(0, 7) == 0);
      sel    = 2'($urandom);
      tick(1);
    end
    idle();
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
